// File: rtl/rgb565_to_hsv.sv
// rgb565_to_hsv: assembles RGB565 byte pairs from the camera into pixels,
// tracks the column within each line and converts every pixel to HSV
// through a fixed three-stage pipeline (S1 unpack, S2 max/min, S3 divide).
module rgb565_to_hsv (
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync,
  input  logic       href,
  input  logic       byte_valid,
  input  logic [7:0] pixel_byte,
  output logic       write,
  output logic [8:0] hue,
  output logic [4:0] saturation,
  output logic [4:0] value,
  output logic [9:0] horiz_count,
  output logic       frame_start
);

  // Which component won the max comparison; selects the hue formula.
  typedef enum logic [1:0] {
    SEL_R = 2'd0,
    SEL_G = 2'd1,
    SEL_B = 2'd2
  } sel_e;

  // ---------------- byte assembly / column counter ----------------
  logic       phase_q, phase_d;
  logic [7:0] byte0_q, byte0_d;
  logic [9:0] col_q, col_d;
  logic       accept, pix_done;

  assign accept   = byte_valid & href & ~vsync;
  assign pix_done = accept & phase_q;

  // Next-state for the byte phase, held first byte and column counter.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    phase_d = phase_q;
    byte0_d = byte0_q;
    col_d   = col_q;
    if (!href || vsync) begin
      phase_d = 1'b0;               // drops any odd trailing byte
    end else if (accept) begin
      phase_d = ~phase_q;
    end
    if (accept && !phase_q) begin
      byte0_d = pixel_byte;
    end
    if (!href) begin
      col_d = '0;
    end else if (pix_done && col_q != 10'd1023) begin
      col_d = col_q + 10'd1;
    end
  end

  // ---------------- S1: unpack components ----------------
  logic       v0_q;
  logic [4:0] r_q, g_q, b_q;
  logic [9:0] col1_q;
  logic [5:0] g6;
  logic [4:0] r_d, g_d, b_d;

  // Split the byte pair into R, 6-bit G (reduced to 5 bits) and B.
  always_comb begin
    g6  = {byte0_q[2:0], pixel_byte[7:5]};
    r_d = byte0_q[7:3];
    g_d = 5'(g6 >> 1);
    b_d = pixel_byte[4:0];
  end

  // ---------------- S2: max / delta / hue numerator ----------------
  logic               v1_q;
  logic [4:0]         max_q, max_d;
  logic [4:0]         delta_q, delta_d;
  logic signed [12:0] num_q, num_d;
  sel_e               sel_q, sel_d;
  logic [9:0]         col2_q;
  logic [4:0]         min_c;
  logic signed [12:0] diff;

  // Pick max with R > G > B tie priority, the min, and the signed numerator.
  always_comb begin
    sel_d = SEL_R;
    max_d = r_q;
    diff  = $signed({8'd0, g_q}) - $signed({8'd0, b_q});
    if (r_q >= g_q && r_q >= b_q) begin
      sel_d = SEL_R;
      max_d = r_q;
      diff  = $signed({8'd0, g_q}) - $signed({8'd0, b_q});
    end else if (g_q >= b_q) begin
      sel_d = SEL_G;
      max_d = g_q;
      diff  = $signed({8'd0, b_q}) - $signed({8'd0, r_q});
    end else begin
      sel_d = SEL_B;
      max_d = b_q;
      diff  = $signed({8'd0, r_q}) - $signed({8'd0, g_q});
    end
    min_c = r_q;
    if (g_q < min_c) min_c = g_q;
    if (b_q < min_c) min_c = b_q;
    delta_d = max_d - min_c;
    num_d   = diff * 13'sd60;
  end

  // ---------------- S3: divides onto the outputs ----------------
  logic       write_q;
  logic [8:0] hue_q, hue_d;
  logic [4:0] sat_q, sat_d;
  logic [4:0] val_q;
  logic [9:0] hcount_q;
  logic signed [12:0] den, quot;
  logic [9:0]         sat_num;

  // Hue offset division (truncates toward zero) and saturation division.
  always_comb begin
    den     = $signed({8'd0, delta_q});
    quot    = (delta_q == 5'd0) ? 13'sd0 : num_q / den;
    sat_num = {5'd0, delta_q} * 10'd31;
    sat_d   = (max_q == 5'd0) ? 5'd0 : 5'(sat_num / {5'd0, max_q});
    hue_d   = '0;
    if (delta_q != 5'd0) begin
      case (sel_q)
        SEL_R:   hue_d = (quot < 0) ? 9'(quot + 13'sd360) : 9'(quot);
        SEL_G:   hue_d = 9'(quot + 13'sd120);
        SEL_B:   hue_d = 9'(quot + 13'sd240);
        default: hue_d = '0;
      endcase
    end
  end

  // ---------------- frame start detect ----------------
  logic vsync_q, frame_start_q;

  // All state: synchronous reset kills in-flight pixels and zeroes outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      phase_q       <= 1'b0;
      byte0_q       <= '0;
      col_q         <= '0;
      v0_q          <= 1'b0;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
      col1_q        <= '0;
      v1_q          <= 1'b0;
      max_q         <= '0;
      delta_q       <= '0;
      num_q         <= '0;
      sel_q         <= SEL_R;
      col2_q        <= '0;
      write_q       <= 1'b0;
      hue_q         <= '0;
      sat_q         <= '0;
      val_q         <= '0;
      hcount_q      <= '0;
      vsync_q       <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      byte0_q <= byte0_d;
      col_q   <= col_d;
      v0_q    <= pix_done;
      if (pix_done) begin
        r_q    <= r_d;
        g_q    <= g_d;
        b_q    <= b_d;
        col1_q <= col_q;
      end
      v1_q <= v0_q;
      if (v0_q) begin
        max_q   <= max_d;
        delta_q <= delta_d;
        num_q   <= num_d;
        sel_q   <= sel_d;
        col2_q  <= col1_q;
      end
      write_q <= v1_q;
      if (v1_q) begin
        hue_q    <= hue_d;
        sat_q    <= sat_d;
        val_q    <= max_q;
        hcount_q <= col2_q;
      end
      vsync_q       <= vsync;
      frame_start_q <= vsync_q & ~vsync;
    end
  end

  assign write       = write_q;
  assign hue         = hue_q;
  assign saturation  = sat_q;
  assign value       = val_q;
  assign horiz_count = hcount_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_rgb565_to_hsv.sv
// Directed bench for rgb565_to_hsv: hand-computed HSV vectors, line/column
// handling, latency, throughput, frame_start and reset behaviour.
module tb_rgb565_to_hsv;

  logic       clk = 1'b0;
  logic       rst;
  logic       vsync;
  logic       href;
  logic       byte_valid;
  logic [7:0] pixel_byte;
  logic       write;
  logic [8:0] hue;
  logic [4:0] saturation;
  logic [4:0] value;
  logic [9:0] horiz_count;
  logic       frame_start;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int         c;
    logic [8:0] h;
    logic [4:0] s;
    logic [4:0] v;
    logic [9:0] col;
  } ev_t;

  ev_t got[$];

  rgb565_to_hsv dut (
    .clk         (clk),
    .rst         (rst),
    .vsync       (vsync),
    .href        (href),
    .byte_valid  (byte_valid),
    .pixel_byte  (pixel_byte),
    .write       (write),
    .hue         (hue),
    .saturation  (saturation),
    .value       (value),
    .horiz_count (horiz_count),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every write strobe with the cycle it was seen in.
  always @(negedge clk) begin
    if (write === 1'b1) got.push_back('{cyc, hue, saturation, value, horiz_count});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One byte with byte_valid for one cycle, then one idle cycle.
  task automatic drive_byte(input logic [7:0] b, output int c);
    @(negedge clk);
    byte_valid = 1'b1;
    pixel_byte = b;
    c = cyc;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic new_line();
    @(negedge clk);
    href = 1'b0;
    @(negedge clk);
    href = 1'b1;
  endtask

  // Pop one recorded write and compare it to the expected sample; c is the
  // cycle in which the second byte was presented.
  task automatic expect_pix(input string tag, input int c, input int h, input int s,
                            input int v, input int col);
    ev_t e;
    check({tag, "_present"}, 32'(got.size() > 0), 32'd1);
    if (got.size() > 0) begin
      e = got.pop_front();
      check({tag, "_cycle"}, 32'(e.c), 32'(c + 3));
      check({tag, "_hue"},   32'(e.h), 32'(h));
      check({tag, "_sat"},   32'(e.s), 32'(s));
      check({tag, "_val"},   32'(e.v), 32'(v));
      check({tag, "_col"},   32'(e.col), 32'(col));
    end
  endtask

  task automatic single(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                        input int h, input int s, input int v);
    int c0, c1;
    new_line();
    drive_byte(b0, c0);
    drive_byte(b1, c1);
    idle(4);
    expect_pix(tag, c1, h, s, v, 0);
    check({tag, "_no_extra"}, 32'(got.size()), 32'd0);
  endtask

  initial begin
    int c0, c1, c2, c3, c4, cx;
    rst        = 1'b1;
    vsync      = 1'b0;
    href       = 1'b0;
    byte_valid = 1'b0;
    pixel_byte = '0;
    idle(3);
    check("rst_write",  32'(write),       32'd0);
    check("rst_hue",    32'(hue),         32'd0);
    check("rst_sat",    32'(saturation),  32'd0);
    check("rst_val",    32'(value),       32'd0);
    check("rst_col",    32'(horiz_count), 32'd0);
    check("rst_fstart", 32'(frame_start), 32'd0);
    rst = 1'b0;
    idle(2);

    // Hand-computed colour vectors.
    single("red",     8'hF8, 8'h00,   0, 31, 31);
    single("green",   8'h07, 8'hE0, 120, 31, 31);
    single("blue",    8'h00, 8'h1F, 240, 31, 31);
    single("yellow",  8'hFF, 8'hE0,  60, 31, 31);
    single("grey",    8'h84, 8'h10,   0,  0, 16);
    single("neg_hue", 8'hF8, 8'h0A, 341, 31, 31);
    // R=10 G=20 B=5: 120 + (-300/15) = 100, 15*31/20 = 23
    single("g_mid",   8'h55, 8'h05, 100, 23, 20);
    // R=5 G=3 B=25: 240 + 120/22 = 245, 22*31/25 = 27
    single("b_mid",   8'h28, 8'hD9, 245, 27, 25);

    // Seven-byte line, odd byte dropped, next line restarts at column 0.
    new_line();
    drive_byte(8'hF8, cx); drive_byte(8'h00, c0);
    drive_byte(8'h07, cx); drive_byte(8'hE0, c1);
    drive_byte(8'h00, cx); drive_byte(8'h1F, c2);
    drive_byte(8'hFF, cx);
    new_line();
    drive_byte(8'h84, cx); drive_byte(8'h10, c3);
    idle(5);
    expect_pix("line_p0", c0,   0, 31, 31, 0);
    expect_pix("line_p1", c1, 120, 31, 31, 1);
    expect_pix("line_p2", c2, 240, 31, 31, 2);
    expect_pix("line2_p0", c3,  0,  0, 16, 0);
    check("line_no_extra", 32'(got.size()), 32'd0);

    // Back-to-back pixels, bytes every other cycle.
    new_line();
    drive_byte(8'h55, cx); drive_byte(8'h05, c0);
    drive_byte(8'h28, cx); drive_byte(8'hD9, c1);
    drive_byte(8'hF8, cx); drive_byte(8'h0A, c2);
    drive_byte(8'hFF, cx); drive_byte(8'hE0, c3);
    idle(5);
    expect_pix("tp_p0", c0, 100, 23, 20, 0);
    expect_pix("tp_p1", c1, 245, 27, 25, 1);
    expect_pix("tp_p2", c2, 341, 31, 31, 2);
    expect_pix("tp_p3", c3,  60, 31, 31, 3);
    check("tp_no_extra", 32'(got.size()), 32'd0);

    // href falls together with the second byte: no pixel.
    new_line();
    drive_byte(8'hF8, cx);
    @(negedge clk);
    href       = 1'b0;
    byte_valid = 1'b1;
    pixel_byte = 8'h00;
    @(negedge clk);
    byte_valid = 1'b0;
    idle(5);
    check("href_fall_no_write", 32'(got.size()), 32'd0);
    href = 1'b1;

    // vsync rises with a pixel in flight; pixel still drains, then frame_start.
    new_line();
    drive_byte(8'h07, cx);
    drive_byte(8'hE0, c4);
    vsync = 1'b1;
    idle(4);
    expect_pix("vsync_drain", c4, 120, 31, 31, 0);
    check("fstart_high_vsync", 32'(frame_start), 32'd0);
    vsync = 1'b0;
    @(negedge clk);
    check("fstart_pulse", 32'(frame_start), 32'd1);
    @(negedge clk);
    check("fstart_one_cycle", 32'(frame_start), 32'd0);

    // Reset one cycle after a pixel's second byte: pixel killed.
    new_line();
    drive_byte(8'hF8, cx);
    drive_byte(8'h00, c4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(5);
    check("rst_kill_no_write", 32'(got.size()), 32'd0);
    check("rst_kill_hue",   32'(hue),         32'd0);
    check("rst_kill_sat",   32'(saturation),  32'd0);
    check("rst_kill_val",   32'(value),       32'd0);
    check("rst_kill_col",   32'(horiz_count), 32'd0);
    check("rst_kill_write", 32'(write),       32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
